fifo_wr_frontend: RTL and testbench
===================================

// Module: fifo_wr_frontend
// PURPOSE
//  Write-domain front end of the async FIFO. Sits directly upstream of the write-pointer/full block.
//  Converts a valid/ready producer stream into winc/wdata for the memory and pointer logic.
//  Holds up to two words in a skid buffer so that s_ready is a registered output.
//  Reports the write-side fill level and an almost-full flag, computed from the pointers.
// PARAMETERS
//  DSIZE         8   data word width
//  ADDRSIZE      4   FIFO address bits; depth = 2**ADDRSIZE
//  AFULL_THRESH  12  walmost_full asserts when wlevel >= this value (legal range 1..2**ADDRSIZE)
// PORTS
//  wclk          in   1            write clock
//  wrst_n        in   1            reset, asynchronous, active-low
//  s_valid       in   1            producer word valid
//  s_ready       out  1            front end can accept a word (registered)
//  s_data        in   DSIZE        producer word
//  winc          out  1            write request to the pointer block and memory
//  wdata         out  DSIZE        word written when winc & ~wfull
//  wfull         in   1            full flag from the pointer block
//  wptr          in   ADDRSIZE+1   Gray-coded write pointer from the pointer block
//  wq2_rptr      in   ADDRSIZE+1   Gray-coded read pointer, synchronised to wclk
//  wlevel        out  ADDRSIZE+1   words in FIFO as seen from the write side (registered)
//  walmost_full  out  1            wlevel >= AFULL_THRESH (registered)
//  wstall_cnt    out  16           stall counter; present only with FIFO_WR_STATS_EN
// BEHAVIOUR
//  Reset: s_ready=0, winc=0, wdata=0, wlevel=0, walmost_full=0, wstall_cnt=0, buffer empty.
//   s_ready rises on the first wclk edge after reset release.
//  Handshakes:
//   push = s_valid & s_ready
//   pop  = winc & ~wfull; a word is committed to memory at the wclk edge where pop=1
//  Skid FSM, state = buffer occupancy:
//   EMPTY: push -> HALF.
//   HALF:  push & ~pop -> FULL; ~push & pop -> EMPTY; push & pop -> HALF (FIFO order kept).
//   FULL:  pop -> HALF; a push cannot occur because s_ready=0.
//  Outputs from the FSM:
//   winc = (state != EMPTY), combinational from state only; never depends on wfull (no comb loop).
//   wdata = head entry; the head holds stable while winc=1 and wfull=1.
//   s_ready <= (next_state != FULL).
//  Throughput and latency:
//   Sustained 1 word/cycle when wfull stays low.
//   s_data to winc latency is 1 cycle.
//   wfull high stalls the head; the buffer fills to 2 and then s_ready drops.
//  Level arithmetic, all ADDRSIZE+1 bits, modulo 2**(ADDRSIZE+1):
//   wlevel <= gray2bin(wptr) - gray2bin(wq2_rptr)
//   The value is pessimistic (overstated) by the synchroniser lag and never exceeds 2**ADDRSIZE.
//   Pointer wrap-around, including MSB toggle, gives the correct difference with no special case.
//  walmost_full <= (level_next >= AFULL_THRESH); it is coincident with wlevel.
//  Words held in the skid buffer are NOT counted in wlevel.
//  Reset mid-operation: buffered words are discarded, and all outputs return to their reset values immediately.
// CONFIGURATION
//  FIFO_WR_STATS_EN defined:
//   wstall_cnt increments each cycle with winc & wfull, saturating at 16'hFFFF; cleared only by reset.
//  FIFO_WR_STATS_EN undefined:
//   the wstall_cnt port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package async_fifo_pkg holds:
//   the FSM state encoding localparams (EMPTY=2'd0, HALF=2'd1, FULL=2'd2);
//   function gray2bin(ADDRSIZE+1).
//  One sub-module: fifo_skid_buf (2-entry buffer + FSM, generic DSIZE).
//  Level and almost-full logic stays in the top module.
// TESTING
//  1. Reset, s_valid=1, wfull=0, data 1..20 -> s_ready=1 from cycle 1, winc every cycle, wdata 1..20 in order.
//  2. Stream active, hold wfull=1 for 5 cycles -> buffer fills (2 words); s_ready=0 one cycle later;
//     no word lost or duplicated after wfull drops.
//  3. wptr=gray(5'd3), wq2_rptr=gray(5'd29), ADDRSIZE=4 -> wlevel=6 next cycle (wrap case).
//  4. wlevel steps 11->12->11 with AFULL_THRESH=12 -> walmost_full 0->1->0, aligned with wlevel.
//  5. Assert wrst_n=0 with 2 buffered words -> winc=0, s_ready=0 at once; after release, no stale word is written.
//  6. FIFO_WR_STATS_EN: 7 cycles of winc & wfull -> wstall_cnt=7; force 70000 stall cycles -> saturates at 65535.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the async FIFO write-side logic.
// Holds the skid-buffer occupancy encoding and the Gray-to-binary converter.
package async_fifo_pkg;

  // Skid buffer occupancy; the value is the number of words held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int unsigned PtrMaxW = 32;

  // Pointers narrower than PtrMaxW are zero-extended by the caller. The leading zeros
  // leave the prefix-XOR of the low bits unchanged, so truncating the result gives the
  // conversion at the pointer's own width (ADDRSIZE+1).
  function automatic logic [PtrMaxW-1:0] gray2bin(input logic [PtrMaxW-1:0] gray);
    logic [PtrMaxW-1:0] bin;
    bin[PtrMaxW-1] = gray[PtrMaxW-1];
    for (int i = PtrMaxW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer turning a valid/ready stream into winc/wdata.
// s_ready is registered; winc depends only on the occupancy state, never on wfull.
module fifo_skid_buf
  import async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_data,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  input  logic             wfull
);

  skid_state_t      state_q, state_d;
  logic [DSIZE-1:0] head_q;
  logic [DSIZE-1:0] tail_q;
  logic             push;
  logic             pop;

  assign push  = s_valid & s_ready;
  assign pop   = winc & ~wfull;
  assign winc  = (state_q != EMPTY);
  assign wdata = head_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (push) state_d = HALF;
      end
      HALF: begin
        if (push && !pop) begin
          state_d = FULL;
        end else if (!push && pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) state_d = HALF;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      s_ready <= 1'b0;
    end else begin
      state_q <= state_d;
      s_ready <= (state_d != FULL);
      unique case (state_q)
        EMPTY: begin
          if (push) head_q <= s_data;
        end
        HALF: begin
          // Simultaneous push and pop: the new word becomes the head directly.
          if (push && pop) begin
            head_q <= s_data;
          end else if (push) begin
            tail_q <= s_data;
          end
        end
        FULL: begin
          if (pop) head_q <= tail_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_wr_frontend.sv
// Write-domain front end of the async FIFO: skid buffer, fill level and almost-full flag.
// Define FIFO_WR_STATS_EN to add the saturating wstall_cnt output.
module fifo_wr_frontend
  import async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE        = 8,
  parameter int unsigned ADDRSIZE     = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DSIZE-1:0]    s_data,
  output logic                winc,
  output logic [DSIZE-1:0]    wdata,
  input  logic                wfull,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                walmost_full
`ifdef FIFO_WR_STATS_EN
  ,
  output logic [15:0]         wstall_cnt
`endif
);

  localparam int unsigned PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] ThreshW = PW'(AFULL_THRESH);

  logic [ADDRSIZE:0] level_next;

  fifo_skid_buf #(
    .DSIZE (DSIZE)
  ) u_skid_buf (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .winc    (winc),
    .wdata   (wdata),
    .wfull   (wfull)
  );

  // Modulo-2**PW subtraction handles pointer wrap, MSB toggle included.
  assign level_next = PW'(gray2bin(PtrMaxW'(wptr))) - PW'(gray2bin(PtrMaxW'(wq2_rptr)));

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wlevel       <= level_next;
      walmost_full <= (level_next >= ThreshW);
    end
  end

`ifdef FIFO_WR_STATS_EN
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wstall_cnt <= '0;
    end else if (winc && wfull && (wstall_cnt != 16'hFFFF)) begin
      wstall_cnt <= wstall_cnt + 16'd1;
    end
  end
`else
  // Stall statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Directed self-checking bench for fifo_wr_frontend (default parameters).
// Stall-counter steps run only when FIFO_WR_STATS_EN is defined.
module tb_fifo_wr_frontend;

  logic       wclk;
  logic       wrst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       winc;
  logic [7:0] wdata;
  logic       wfull;
  logic [4:0] wptr;
  logic [4:0] wq2_rptr;
  logic [4:0] wlevel;
  logic       walmost_full;
`ifdef FIFO_WR_STATS_EN
  logic [15:0] wstall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  fifo_wr_frontend #(
    .DSIZE        (8),
    .ADDRSIZE     (4),
    .AFULL_THRESH (12)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .winc         (winc),
    .wdata        (wdata),
    .wfull        (wfull),
    .wptr         (wptr),
    .wq2_rptr     (wq2_rptr),
    .wlevel       (wlevel),
    .walmost_full (walmost_full)
`ifdef FIFO_WR_STATS_EN
    ,
    .wstall_cnt   (wstall_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    wrst_n   = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'd0;
    wfull    = 1'b0;
    wptr     = 5'd0;
    wq2_rptr = 5'd0;

    // Reset values
    repeat (2) @(negedge wclk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_winc", 32'(winc), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_wlevel", 32'(wlevel), 32'd0);
    chk("rst_afull", 32'(walmost_full), 32'd0);
`ifdef FIFO_WR_STATS_EN
    chk("rst_wstall", 32'(wstall_cnt), 32'd0);
`endif

    // 1: stream 1..20 with wfull low
    wrst_n  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'd1;
    @(negedge wclk);
    chk("t1_ready_c1", 32'(s_ready), 32'd1);
    chk("t1_winc_c1", 32'(winc), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge wclk);
      chk("t1_winc", 32'(winc), 32'd1);
      chk("t1_wdata", 32'(wdata), 32'(i));
      chk("t1_ready", 32'(s_ready), 32'd1);
      if (i == 20) s_valid = 1'b0;
      else s_data = 8'(i + 1);
    end
    @(negedge wclk);
    chk("t1_drain", 32'(winc), 32'd0);

    // 2: wfull held for 5 edges while streaming
    s_valid = 1'b1;
    s_data  = 8'h21;
    @(negedge wclk);
    chk("t2_head", 32'(wdata), 32'h21);
    wfull  = 1'b1;
    s_data = 8'h22;
    @(negedge wclk);
    chk("t2_ready_drop", 32'(s_ready), 32'd0);
    chk("t2_hold0", 32'(wdata), 32'h21);
    s_data = 8'h23;
    for (int i = 0; i < 4; i++) begin
      @(negedge wclk);
      chk("t2_hold_wdata", 32'(wdata), 32'h21);
      chk("t2_hold_winc", 32'(winc), 32'd1);
      chk("t2_hold_ready", 32'(s_ready), 32'd0);
    end
    wfull = 1'b0;
    @(negedge wclk);
    chk("t2_pop1", 32'(wdata), 32'h22);
    chk("t2_ready_back", 32'(s_ready), 32'd1);
    @(negedge wclk);
    chk("t2_pop2", 32'(wdata), 32'h23);
    chk("t2_pop2_winc", 32'(winc), 32'd1);
    s_valid = 1'b0;
    @(negedge wclk);
    chk("t2_empty", 32'(winc), 32'd0);

    // 3: level across pointer wrap: 3 - 29 mod 32 = 6
    wptr     = gray(5'd3);
    wq2_rptr = gray(5'd29);
    @(negedge wclk);
    chk("t3_wrap_level", 32'(wlevel), 32'd6);
    chk("t3_wrap_afull", 32'(walmost_full), 32'd0);

    // 4: threshold crossing 11 -> 12 -> 11, then full and MSB-toggle wrap
    wptr     = gray(5'd11);
    wq2_rptr = gray(5'd0);
    @(negedge wclk);
    chk("t4_lvl11", 32'(wlevel), 32'd11);
    chk("t4_af11", 32'(walmost_full), 32'd0);
    wptr = gray(5'd12);
    @(negedge wclk);
    chk("t4_lvl12", 32'(wlevel), 32'd12);
    chk("t4_af12", 32'(walmost_full), 32'd1);
    wptr = gray(5'd11);
    @(negedge wclk);
    chk("t4_lvl11b", 32'(wlevel), 32'd11);
    chk("t4_af11b", 32'(walmost_full), 32'd0);
    wptr     = gray(5'd18);
    wq2_rptr = gray(5'd2);
    @(negedge wclk);
    chk("t4_lvl16", 32'(wlevel), 32'd16);
    chk("t4_af16", 32'(walmost_full), 32'd1);

    // 5: reset with two buffered words
    s_valid = 1'b1;
    s_data  = 8'h51;
    wfull   = 1'b1;
    @(negedge wclk);
    s_data = 8'h52;
    @(negedge wclk);
    chk("t5_full_ready", 32'(s_ready), 32'd0);
    chk("t5_full_winc", 32'(winc), 32'd1);
    wrst_n = 1'b0;
    #1;
    chk("t5_async_winc", 32'(winc), 32'd0);
    chk("t5_async_ready", 32'(s_ready), 32'd0);
    chk("t5_async_wdata", 32'(wdata), 32'd0);
    chk("t5_async_wlevel", 32'(wlevel), 32'd0);
    chk("t5_async_afull", 32'(walmost_full), 32'd0);
    s_valid  = 1'b0;
    wfull    = 1'b0;
    wptr     = 5'd0;
    wq2_rptr = 5'd0;
    @(negedge wclk);
    wrst_n = 1'b1;
    @(negedge wclk);
    chk("t5_rel_ready", 32'(s_ready), 32'd1);
    chk("t5_rel_winc", 32'(winc), 32'd0);
    @(negedge wclk);
    chk("t5_no_stale", 32'(winc), 32'd0);

`ifdef FIFO_WR_STATS_EN
    // 6: stall counting and saturation
    chk("t6_cnt_after_rst", 32'(wstall_cnt), 32'd0);
    s_valid = 1'b1;
    s_data  = 8'h61;
    wfull   = 1'b1;
    @(negedge wclk);
    s_valid = 1'b0;
    repeat (7) @(negedge wclk);
    chk("t6_cnt7", 32'(wstall_cnt), 32'd7);
    repeat (70000) @(negedge wclk);
    chk("t6_saturate", 32'(wstall_cnt), 32'd65535);
    wfull = 1'b0;
    @(negedge wclk);
    chk("t6_hold_after", 32'(wstall_cnt), 32'd65535);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
